// File: rtl/regwb_arbiter.sv
// regwb_arbiter: two-requester register-file writeback arbiter.
//   The ALU and load ports each own a one-entry holding slot. One slot is
//   granted per cycle (older first, load on a same-edge tie) and the granted
//   slot is written to the register file on the following edge.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   alu_valid/reg/data, alu_ready  ALU writeback request (valid/ready)
//   ld_valid/reg/data,  ld_ready   load writeback request (valid/ready)
//   regWrite/writeReg/writeData    registered register-file write port
//   pending                        per-register write-in-flight bitmap
//   conflict_cnt                   saturating count of both-slots-full edges
module regwb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_reg,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [4:0]       ld_reg,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             regWrite,
  output logic [4:0]       writeReg,
  output logic [31:0]      writeData,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             r_alu_full, r_ld_full, r_ld_older;
  logic [4:0]       r_alu_reg, r_ld_reg, r_wreg;
  logic [31:0]      r_alu_data, r_ld_data, r_wdata;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;

  logic w_gnt_alu, w_gnt_ld;
  logic w_alu_fill, w_ld_fill, w_alu_hold, w_ld_hold;
  logic [31:0] w_pend;

  // Grant depends on slot state only, so ready never depends on valid.
  assign w_gnt_alu = r_alu_full & (~r_ld_full | ~r_ld_older);
  assign w_gnt_ld  = r_ld_full  & (~r_alu_full | r_ld_older);

  assign alu_ready = ~r_alu_full | w_gnt_alu;
  assign ld_ready  = ~r_ld_full  | w_gnt_ld;

  // A register-0 transfer is accepted but never occupies the slot.
  assign w_alu_fill = alu_valid & alu_ready & (alu_reg != 5'd0);
  assign w_ld_fill  = ld_valid  & ld_ready  & (ld_reg  != 5'd0);

  // Slot keeps its old content across this edge (full and not granted).
  assign w_alu_hold = r_alu_full & ~w_gnt_alu;
  assign w_ld_hold  = r_ld_full  & ~w_gnt_ld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_full <= 1'b0;
      r_alu_reg  <= '0;
      r_alu_data <= '0;
      r_ld_full  <= 1'b0;
      r_ld_reg   <= '0;
      r_ld_data  <= '0;
      r_ld_older <= 1'b0;
      r_we       <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_alu_fill) begin
        r_alu_full <= 1'b1;
        r_alu_reg  <= alu_reg;
        r_alu_data <= alu_data;
      end else if (w_gnt_alu) begin
        r_alu_full <= 1'b0;
      end

      if (w_ld_fill) begin
        r_ld_full <= 1'b1;
        r_ld_reg  <= ld_reg;
        r_ld_data <= ld_data;
      end else if (w_gnt_ld) begin
        r_ld_full <= 1'b0;
      end

      // Load is older when it lands next to an empty/same-edge ALU slot, or
      // when a fresh ALU entry arrives behind a held load. A load landing
      // behind a held ALU entry makes the ALU the older one.
      if (w_ld_fill)
        r_ld_older <= w_alu_fill | ~w_alu_hold;
      else if (w_alu_fill && w_ld_hold)
        r_ld_older <= 1'b1;

      r_we <= w_gnt_alu | w_gnt_ld;
      if (w_gnt_ld) begin
        r_wreg  <= r_ld_reg;
        r_wdata <= r_ld_data;
      end else if (w_gnt_alu) begin
        r_wreg  <= r_alu_reg;
        r_wdata <= r_alu_data;
      end

      if (r_alu_full && r_ld_full && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_pend = '0;
    if (r_alu_full) w_pend[r_alu_reg] = 1'b1;
    if (r_ld_full)  w_pend[r_ld_reg]  = 1'b1;
    if (r_we)       w_pend[r_wreg]    = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign regWrite     = r_we;
  assign writeReg     = r_wreg;
  assign writeData    = r_wdata;
  assign pending      = w_pend;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Bench for regwb_arbiter: directed scenarios with literal expectations plus
// an age-stamp reference model compared against the DUT every cycle.
module tb_regwb_arbiter;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clock, reset_n;
  logic alu_valid, ld_valid, alu_ready, ld_ready, regWrite;
  logic [4:0] alu_reg, ld_reg, writeReg;
  logic [31:0] alu_data, ld_data, writeData, pending;
  logic [CW-1:0] conflict_cnt;

  regwb_arbiter #(.CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .pending(pending), .conflict_cnt(conflict_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = ALU, 1 = load) -------------
  // Each slot remembers the edge number it was filled on; the smaller stamp
  // is older, equal stamps favour the load.
  logic        m_full[2];
  logic [4:0]  m_reg[2];
  logic [31:0] m_data[2];
  int          m_stamp[2];
  logic        m_xfer[2];
  int          edge_n, m_cnt;
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  function automatic int mgrant();
    if (!m_full[0] && !m_full[1]) return -1;
    if (!m_full[0]) return 1;
    if (!m_full[1]) return 0;
    return (m_stamp[1] <= m_stamp[0]) ? 1 : 0;
  endfunction

  function automatic logic mready(input int i);
    return !m_full[i] || (mgrant() == i);
  endfunction

  function automatic logic [31:0] mpend();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 2; i++) if (m_full[i]) p[m_reg[i]] = 1'b1;
    if (m_we) p[m_wr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_full[i] <= 1'b0; m_reg[i] <= '0; m_data[i] <= '0;
        m_stamp[i] <= 0; m_xfer[i] <= 1'b0;
      end
      m_we <= 1'b0; m_wr <= '0; m_wd <= '0; m_cnt <= 0; edge_n <= 0;
    end else begin
      edge_n <= edge_n + 1;
      if (m_full[0] && m_full[1] && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      m_we <= (mgrant() >= 0);
      if (mgrant() >= 0) begin
        m_wr <= m_reg[mgrant()];
        m_wd <= m_data[mgrant()];
        m_full[mgrant()] <= 1'b0;
      end
      m_xfer[0] <= alu_valid && mready(0);
      m_xfer[1] <= ld_valid && mready(1);
      if (alu_valid && mready(0) && alu_reg != 5'd0) begin
        m_full[0] <= 1'b1; m_reg[0] <= alu_reg; m_data[0] <= alu_data; m_stamp[0] <= edge_n;
      end
      if (ld_valid && mready(1) && ld_reg != 5'd0) begin
        m_full[1] <= 1'b1; m_reg[1] <= ld_reg; m_data[1] <= ld_data; m_stamp[1] <= edge_n;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("alu_ready", 32'(alu_ready), 32'(mready(0)));
    chk("ld_ready", 32'(ld_ready), 32'(mready(1)));
    chk("regWrite", 32'(regWrite), 32'(m_we));
    chk("writeReg", 32'(writeReg), 32'(m_wr));
    chk("writeData", writeData, m_wd);
    chk("pending", pending, mpend());
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
    @(negedge clock);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid = lv; ld_reg = lr; ld_data = ldd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    ld_valid = 0; ld_reg = 0; ld_data = 0;
    #1;
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_pending", pending, 32'd0);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  int aseq, lseq, awr, lwr;
  logic pa, pl;

  initial begin
    reset_n = 1'b0;
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    ld_valid = 0; ld_reg = 0; ld_data = 0;
    do_reset();

    // Single ALU write, uncontended.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle();
    chk("s1_pend_c1", pending, 32'h0000_0020);
    chk("s1_we_c1", 32'(regWrite), 32'd0);
    idle();
    chk("s1_we_c2", 32'(regWrite), 32'd1);
    chk("s1_wreg", 32'(writeReg), 32'd5);
    chk("s1_wdata", writeData, 32'hDEADBEEF);
    chk("s1_pend_c2", pending, 32'h0000_0020);
    idle();
    chk("s1_we_c3", 32'(regWrite), 32'd0);
    chk("s1_pend_c3", pending, 32'd0);
    chk("s1_hold", writeData, 32'hDEADBEEF);

    // Simultaneous fill: load first, then ALU; one conflict edge.
    do_reset();
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle();
    chk("s2_pend", pending, 32'h0000_0018);
    idle();
    chk("s2_w1_reg", 32'(writeReg), 32'd4);
    chk("s2_w1_data", writeData, 32'h22);
    chk("s2_cnt", 32'(conflict_cnt), 32'd1);
    idle();
    chk("s2_w2_we", 32'(regWrite), 32'd1);
    chk("s2_w2_reg", 32'(writeReg), 32'd3);
    chk("s2_w2_data", writeData, 32'h11);
    idle();
    chk("s2_done", 32'(regWrite), 32'd0);
    chk("s2_cnt_end", 32'(conflict_cnt), 32'd1);

    // Same-register ordering: load r7 then ALU r7.
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    idle();
    chk("s3_first", writeData, 32'hAA);
    idle();
    chk("s3_second", writeData, 32'hBB);
    chk("s3_reg", 32'(writeReg), 32'd7);

    // Zero register: accepted, never written.
    do_reset();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    chk("s4_ready", 32'(alu_ready), 32'd1);
    idle();
    chk("s4_pend", pending, 32'd0);
    chk("s4_ready2", 32'(alu_ready), 32'd1);
    idle();
    chk("s4_we", 32'(regWrite), 32'd0);

    // Backpressure: both streaming for 20 edges.
    do_reset();
    aseq = 0; lseq = 0; awr = 0; lwr = 0; pa = 1'b1; pl = 1'b1;
    drive(1'b1, 5'd1, 32'h0, 1'b1, 5'd8, 32'h8000_0000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("s5_alu_2low", 32'(pa | alu_ready), 32'd1);
      chk("s5_ld_2low", 32'(pl | ld_ready), 32'd1);
      pa = alu_ready; pl = ld_ready;
      if (regWrite) begin
        if (writeData[31]) lwr++; else awr++;
      end
      if (m_xfer[0]) begin
        aseq++; alu_reg = 5'((aseq % 31) + 1); alu_data = {1'b0, 31'(aseq)};
      end
      if (m_xfer[1]) begin
        lseq++; ld_reg = 5'(((lseq + 7) % 31) + 1); ld_data = {1'b1, 31'(lseq)};
      end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (regWrite) begin
        if (writeData[31]) lwr++; else awr++;
      end
    end
    chk("s5_alu_writes", 32'(awr >= 9), 32'd1);
    chk("s5_ld_writes", 32'(lwr >= 9), 32'd1);
    chk("s5_cnt_sat", 32'(conflict_cnt), 32'd3);

    // Mid-operation reset with both slots full.
    do_reset();
    drive(1'b1, 5'd10, 32'h1010, 1'b1, 5'd11, 32'h1111);
    idle();
    chk("s6_pend_before", pending, 32'h0000_0C00);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_we", 32'(regWrite), 32'd0);
    chk("s6_rst_pend", pending, 32'd0);
    chk("s6_rst_ardy", 32'(alu_ready), 32'd1);
    chk("s6_rst_lrdy", 32'(ld_ready), 32'd1);
    chk("s6_rst_wdata", writeData, 32'd0);
    #1 reset_n = 1'b1;
    idle();
    chk("s6_we1", 32'(regWrite), 32'd0);
    idle();
    chk("s6_we2", 32'(regWrite), 32'd0);
    chk("s6_pend_after", pending, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
